// File: rtl/lcd_rd_pkg.sv
// Shared definitions for the LCD1602 read-side controller: FSM state
// encoding, default 50 MHz timing constants, RS encoding and a small
// saturating-increment helper used by the poll counter.
package lcd_rd_pkg;

    // Read-cycle phases, in the order a single read walks through them.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        EHIGH   = 3'd2,
        HOLD    = 3'd3,
        RECOVER = 3'd4,
        FIN     = 3'd5
    } state_e;

    // Default timing in 50 MHz clock cycles.
    localparam int unsigned T_AS_DEF     = 3;
    localparam int unsigned T_PW_DEF     = 25;
    localparam int unsigned T_H_DEF      = 2;
    localparam int unsigned T_REC_DEF    = 25;
    localparam int unsigned MAX_POLL_DEF = 1000;

    // Panel RS encoding: instruction register (BF/AC) vs data RAM.
    localparam logic RS_INSTR = 1'b0;
    localparam logic RS_DATA  = 1'b1;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/lcd_rd_ctrl_if.sv
// Request/response and panel-pin bundle for the LCD read controller.
// master = the requesting client (also supplies the panel data bus),
// slave  = the controller itself.
interface lcd_rd_ctrl_if;

    logic       REQ;
    logic       RS_SEL;
    logic       POLL;
    logic       BUSY;
    logic       BUS_OWN;
    logic       DONE;
    logic [7:0] DOUT;
    logic       BF;
    logic [6:0] AC;
    logic       TIMEOUT;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_E;
    logic [7:0] DB_I;

    modport master (
        output REQ, RS_SEL, POLL, DB_I,
        input  BUSY, BUS_OWN, DONE, DOUT, BF, AC, TIMEOUT,
        input  LCD_RS, LCD_RW, LCD_E
    );

    modport slave (
        input  REQ, RS_SEL, POLL, DB_I,
        output BUSY, BUS_OWN, DONE, DOUT, BF, AC, TIMEOUT,
        output LCD_RS, LCD_RW, LCD_E
    );

endinterface

// File: rtl/lcd_rd_timer.sv
// 8-bit loadable down-counter that paces each read-cycle phase.
// Loaded with (cycles-1) on phase entry; o_zero marks the phase's last cycle.
module lcd_rd_timer (
    input  logic       C,
    input  logic       nR,
    input  logic       i_load,
    input  logic [7:0] i_value,
    output logic       o_zero
);

    logic [7:0] r_cnt;

    // Load on request, otherwise count down and rest at zero.
    always_ff @(posedge C or negedge nR) begin
        // NOTE: clocked state always uses non-blocking assignments so every
        // register sees pre-edge values and simulation matches the netlist.
        if (!nR) begin
            r_cnt <= 8'd0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign o_zero = (r_cnt == 8'd0);

endmodule

// File: rtl/lcd_rd_ctrl.sv
// LCD1602 read-side bus controller. Runs one RW=1 read cycle per request
// (setup, E pulse, hold, recovery), samples DB at the end of the E pulse,
// and optionally repeats busy-flag reads until BF clears or a limit is hit.
module lcd_rd_ctrl
    import lcd_rd_pkg::*;
#(
    parameter int unsigned T_AS     = T_AS_DEF,
    parameter int unsigned T_PW     = T_PW_DEF,
    parameter int unsigned T_H      = T_H_DEF,
    parameter int unsigned T_REC    = T_REC_DEF,
    parameter int unsigned MAX_POLL = MAX_POLL_DEF
) (
    input  logic         C,
    input  logic         nR,
    lcd_rd_ctrl_if.slave bus
);

    // Timer reload values: a phase of N cycles loads N-1.
    localparam logic [7:0]  LD_AS    = 8'(T_AS - 1);
    localparam logic [7:0]  LD_PW    = 8'(T_PW - 1);
    localparam logic [7:0]  LD_H     = 8'(T_H - 1);
    localparam logic [7:0]  LD_REC   = 8'(T_REC - 1);
    localparam logic [15:0] POLL_LIM = 16'(MAX_POLL);

    state_e      r_state,    w_state_nxt;
    logic        r_rs_lat,   w_rs_lat_nxt;
    logic        r_poll_lat, w_poll_lat_nxt;
    logic [15:0] r_poll_cnt, w_poll_cnt_nxt;
    logic [7:0]  r_dout,     w_dout_nxt;
    logic        r_bf,       w_bf_nxt;
    logic [6:0]  r_ac,       w_ac_nxt;
    logic        r_timeout,  w_timeout_nxt;
    logic        r_done,     w_done_nxt;
    logic        r_busy,     w_busy_nxt;
    logic        r_bus_own,  w_bus_own_nxt;
    logic        r_lcd_rs,   w_lcd_rs_nxt;
    logic        r_lcd_rw,   w_lcd_rw_nxt;
    logic        r_lcd_e,    w_lcd_e_nxt;

    logic        w_tmr_load;
    logic [7:0]  w_tmr_value;
    logic        w_tmr_zero;
    logic        w_still_busy;

    lcd_rd_timer u_timer (
        .C       (C),
        .nR      (nR),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_value),
        .o_zero  (w_tmr_zero)
    );

    // Another poll round is wanted when polling and the last BF read was 1.
    assign w_still_busy = r_poll_lat && r_dout[7];

    // Next-state and next-output logic for the read sequence.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        w_state_nxt    = r_state;
        w_rs_lat_nxt   = r_rs_lat;
        w_poll_lat_nxt = r_poll_lat;
        w_poll_cnt_nxt = r_poll_cnt;
        w_dout_nxt     = r_dout;
        w_bf_nxt       = r_bf;
        w_ac_nxt       = r_ac;
        w_timeout_nxt  = r_timeout;
        w_done_nxt     = 1'b0;
        w_busy_nxt     = r_busy;
        w_bus_own_nxt  = r_bus_own;
        w_lcd_rs_nxt   = r_lcd_rs;
        w_lcd_rw_nxt   = r_lcd_rw;
        w_lcd_e_nxt    = r_lcd_e;
        w_tmr_load     = 1'b0;
        w_tmr_value    = 8'd0;

        case (r_state)
            IDLE: begin
                w_lcd_rw_nxt = 1'b0;
                w_lcd_e_nxt  = 1'b0;
                if (bus.REQ) begin
                    w_rs_lat_nxt   = bus.RS_SEL;
                    w_poll_lat_nxt = bus.POLL && (bus.RS_SEL == RS_INSTR);
                    w_lcd_rs_nxt   = bus.RS_SEL;
                    w_lcd_rw_nxt   = 1'b1;
                    w_busy_nxt     = 1'b1;
                    w_bus_own_nxt  = 1'b1;
                    w_poll_cnt_nxt = 16'd1;
                    w_timeout_nxt  = 1'b0;
                    w_tmr_load     = 1'b1;
                    w_tmr_value    = LD_AS;
                    w_state_nxt    = SETUP;
                end
            end

            SETUP: begin
                if (w_tmr_zero) begin
                    w_lcd_e_nxt = 1'b1;
                    w_tmr_load  = 1'b1;
                    w_tmr_value = LD_PW;
                    w_state_nxt = EHIGH;
                end
            end

            EHIGH: begin
                // Panel data is valid by the last E-high cycle; capture it
                // on the same edge that drops E.
                if (w_tmr_zero) begin
                    w_dout_nxt  = bus.DB_I;
                    w_lcd_e_nxt = 1'b0;
                    w_tmr_load  = 1'b1;
                    w_tmr_value = LD_H;
                    w_state_nxt = HOLD;
                end
            end

            HOLD: begin
                if (w_tmr_zero) begin
                    w_lcd_rw_nxt  = 1'b0;
                    w_bus_own_nxt = 1'b0;
                    w_tmr_load    = 1'b1;
                    w_tmr_value   = LD_REC;
                    w_state_nxt   = RECOVER;
                end
            end

            RECOVER: begin
                if (w_tmr_zero) begin
                    if (w_still_busy && (r_poll_cnt < POLL_LIM)) begin
                        w_poll_cnt_nxt = sat_inc16(r_poll_cnt);
                        w_lcd_rw_nxt   = 1'b1;
                        w_bus_own_nxt  = 1'b1;
                        w_tmr_load     = 1'b1;
                        w_tmr_value    = LD_AS;
                        w_state_nxt    = SETUP;
                    end else begin
                        w_timeout_nxt = w_still_busy;
                        w_done_nxt    = 1'b1;
                        if (r_rs_lat == RS_DATA) begin
                            w_bf_nxt = 1'b0;
                            w_ac_nxt = 7'd0;
                        end else begin
                            w_bf_nxt = r_dout[7];
                            w_ac_nxt = r_dout[6:0];
                        end
                        w_state_nxt = FIN;
                    end
                end
            end

            FIN: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end

            default: begin
                w_lcd_rw_nxt  = 1'b0;
                w_lcd_e_nxt   = 1'b0;
                w_bus_own_nxt = 1'b0;
                w_busy_nxt    = 1'b0;
                w_state_nxt   = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops E and RW at once.
    always_ff @(posedge C or negedge nR) begin
        if (!nR) begin
            r_state    <= IDLE;
            r_rs_lat   <= 1'b0;
            r_poll_lat <= 1'b0;
            r_poll_cnt <= 16'd0;
            r_dout     <= 8'd0;
            r_bf       <= 1'b0;
            r_ac       <= 7'd0;
            r_timeout  <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_bus_own  <= 1'b0;
            r_lcd_rs   <= 1'b0;
            r_lcd_rw   <= 1'b0;
            r_lcd_e    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rs_lat   <= w_rs_lat_nxt;
            r_poll_lat <= w_poll_lat_nxt;
            r_poll_cnt <= w_poll_cnt_nxt;
            r_dout     <= w_dout_nxt;
            r_bf       <= w_bf_nxt;
            r_ac       <= w_ac_nxt;
            r_timeout  <= w_timeout_nxt;
            r_done     <= w_done_nxt;
            r_busy     <= w_busy_nxt;
            r_bus_own  <= w_bus_own_nxt;
            r_lcd_rs   <= w_lcd_rs_nxt;
            r_lcd_rw   <= w_lcd_rw_nxt;
            r_lcd_e    <= w_lcd_e_nxt;
        end
    end

    assign bus.BUSY    = r_busy;
    assign bus.BUS_OWN = r_bus_own;
    assign bus.DONE    = r_done;
    assign bus.DOUT    = r_dout;
    assign bus.BF      = r_bf;
    assign bus.AC      = r_ac;
    assign bus.TIMEOUT = r_timeout;
    assign bus.LCD_RS  = r_lcd_rs;
    assign bus.LCD_RW  = r_lcd_rw;
    assign bus.LCD_E   = r_lcd_e;

endmodule

// File: tb/tb_lcd_rd_ctrl.sv
// Self-checking bench for lcd_rd_ctrl: directed and randomized reads on a
// default instance and a MAX_POLL=4 instance, compared with a transaction
// model of the read/poll rules and a cycle-timing monitor.
module tb_lcd_rd_ctrl;

    localparam int T_AS     = 3;
    localparam int T_PW     = 25;
    localparam int T_H      = 2;
    localparam int T_REC    = 25;
    localparam int CYC      = T_AS + T_PW + T_H + T_REC;
    localparam int POLL_BIG = 1000;
    localparam int POLL_LIM = 4;

    typedef logic [7:0] byte_q_t[$];

    logic C  = 1'b0;
    logic nR = 1'b0;
    always #5 C = ~C;

    lcd_rd_ctrl_if bus0 ();
    lcd_rd_ctrl_if bus1 ();

    lcd_rd_ctrl #(.MAX_POLL(POLL_BIG)) dut (
        .C   (C),
        .nR  (nR),
        .bus (bus0)
    );

    lcd_rd_ctrl #(.MAX_POLL(POLL_LIM)) dut_lim (
        .C   (C),
        .nR  (nR),
        .bus (bus1)
    );

    // Stimulus: t_sel picks which instance receives the request.
    logic       t_req  = 1'b0;
    logic       t_rs   = 1'b0;
    logic       t_poll = 1'b0;
    logic       t_sel  = 1'b0;
    logic [7:0] db0    = 8'd0;
    logic [7:0] db1    = 8'd0;
    byte_q_t    q0;
    byte_q_t    q1;

    assign bus0.REQ    = t_req & ~t_sel;
    assign bus0.RS_SEL = t_rs;
    assign bus0.POLL   = t_poll;
    assign bus0.DB_I   = db0;
    assign bus1.REQ    = t_req & t_sel;
    assign bus1.RS_SEL = t_rs;
    assign bus1.POLL   = t_poll;
    assign bus1.DB_I   = db1;

    // Observed signals of the selected instance.
    wire       m_busy    = t_sel ? bus1.BUSY    : bus0.BUSY;
    wire       m_bus_own = t_sel ? bus1.BUS_OWN : bus0.BUS_OWN;
    wire       m_done    = t_sel ? bus1.DONE    : bus0.DONE;
    wire [7:0] m_dout    = t_sel ? bus1.DOUT    : bus0.DOUT;
    wire       m_bf      = t_sel ? bus1.BF      : bus0.BF;
    wire [6:0] m_ac      = t_sel ? bus1.AC      : bus0.AC;
    wire       m_timeout = t_sel ? bus1.TIMEOUT : bus0.TIMEOUT;
    wire       m_lcd_rs  = t_sel ? bus1.LCD_RS  : bus0.LCD_RS;
    wire       m_lcd_rw  = t_sel ? bus1.LCD_RW  : bus0.LCD_RW;
    wire       m_lcd_e   = t_sel ? bus1.LCD_E   : bus0.LCD_E;

    // Panel model: each completed E pulse advances to the next queued byte.
    always @(negedge bus0.LCD_E) begin
        if (q0.size() > 1) begin
            void'(q0.pop_front());
            db0 = q0[0];
        end
    end

    always @(negedge bus1.LCD_E) begin
        if (q1.size() > 1) begin
            void'(q1.pop_front());
            db1 = q1[0];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Transaction model: how many E pulses a request takes and what it returns.
    function automatic void model(input bit rs, input bit poll, input byte_q_t data,
                                  input int max_poll, output int n_rd,
                                  output logic [7:0] dout, output logic bf,
                                  output logic [6:0] ac, output logic to);
        logic [7:0] v;
        v    = 8'd0;
        n_rd = 0;
        to   = 1'b0;
        for (int i = 0; i < max_poll; i++) begin
            v    = data[(i < data.size()) ? i : data.size() - 1];
            n_rd = i + 1;
            if (!(poll && !rs && v[7])) break;
            if (n_rd == max_poll) to = 1'b1;
        end
        dout = v;
        bf   = rs ? 1'b0 : v[7];
        ac   = rs ? 7'd0 : v[6:0];
    endfunction

    // One request on instance sel, with cycle-level timing checks.
    task automatic do_read(input bit sel, input bit rs, input bit poll,
                           input byte_q_t data, input string tag);
        int         exp_n;
        logic [7:0] exp_dout;
        logic       exp_bf;
        logic [6:0] exp_ac;
        logic       exp_to;
        int         j, pulses, first_rise, e_high, e_fall_j, done_j;
        int         bad_width, bad_hold, rs_bad, own_bad;
        logic       prev_e, prev_rw;

        model(rs, poll, data, sel ? POLL_LIM : POLL_BIG, exp_n, exp_dout, exp_bf, exp_ac, exp_to);

        @(negedge C);
        if (sel) begin
            q1  = data;
            db1 = data[0];
        end else begin
            q0  = data;
            db0 = data[0];
        end
        t_sel  = sel;
        t_rs   = rs;
        t_poll = poll;
        t_req  = 1'b1;
        @(negedge C);
        t_req = 1'b0;

        check({tag, ".busy_on"}, m_busy, 1'b1);
        j = 0; pulses = 0; first_rise = -1; e_high = 0; e_fall_j = -1; done_j = -1;
        bad_width = 0; bad_hold = 0; rs_bad = 0; own_bad = 0;
        prev_e = 1'b0; prev_rw = 1'b1;
        while (j < exp_n * CYC + 20) begin
            if (m_lcd_rs !== rs) rs_bad++;
            if (m_bus_own !== m_lcd_rw) own_bad++;
            if (m_lcd_e && !prev_e) begin
                pulses++;
                if (first_rise < 0) first_rise = j;
                e_high = 0;
            end
            if (m_lcd_e) e_high++;
            if (!m_lcd_e && prev_e) begin
                if (e_high != T_PW) bad_width++;
                e_fall_j = j;
            end
            if (!m_lcd_rw && prev_rw) begin
                if (j - e_fall_j != T_H) bad_hold++;
            end
            if (m_done) begin
                done_j = j;
                break;
            end
            prev_e  = m_lcd_e;
            prev_rw = m_lcd_rw;
            @(negedge C);
            j++;
        end

        check({tag, ".e_rise"},    first_rise, T_AS);
        check({tag, ".pulses"},    pulses, exp_n);
        check({tag, ".e_width"},   bad_width, 0);
        check({tag, ".rw_hold"},   bad_hold, 0);
        check({tag, ".rs_stable"}, rs_bad, 0);
        check({tag, ".bus_own"},   own_bad, 0);
        check({tag, ".latency"},   done_j, exp_n * CYC);
        check({tag, ".dout"},      m_dout, exp_dout);
        check({tag, ".bf"},        m_bf, exp_bf);
        check({tag, ".ac"},        m_ac, exp_ac);
        check({tag, ".timeout"},   m_timeout, exp_to);
        check({tag, ".busy_fin"},  m_busy, 1'b1);
        @(negedge C);
        check({tag, ".done_1cyc"}, m_done, 1'b0);
        check({tag, ".busy_off"},  m_busy, 1'b0);
        check({tag, ".dout_hold"}, m_dout, exp_dout);
    endtask

    initial begin
        byte_q_t d;
        logic [7:0] last;
        int nb, done_cnt, gaps, bad_gap, low_run, found;
        bit rs, poll;
        bit seen_busy;

        repeat (3) @(negedge C);
        check("rst.busy",   bus0.BUSY, 1'b0);
        check("rst.e",      bus0.LCD_E, 1'b0);
        check("rst.rw",     bus0.LCD_RW, 1'b0);
        check("rst.done",   bus0.DONE, 1'b0);
        check("rst.dout",   bus0.DOUT, 8'h00);
        check("rst.lim_rw", bus1.LCD_RW, 1'b0);
        nR = 1'b1;
        @(negedge C);

        // Directed cases.
        d = {8'h25};
        do_read(1'b0, 1'b0, 1'b0, d, "bf_ac");
        d = {8'hC1};
        do_read(1'b0, 1'b1, 1'b0, d, "data");
        d = {8'h80, 8'h80, 8'h80, 8'h0A};
        do_read(1'b0, 1'b0, 1'b1, d, "poll4");
        d = {8'hFF};
        do_read(1'b1, 1'b0, 1'b1, d, "poll_to");

        // Randomized reads on the default instance (polls always end).
        for (int i = 0; i < 8; i++) begin
            rs   = 1'($urandom);
            poll = 1'($urandom);
            nb   = $urandom_range(0, 3);
            d    = {};
            for (int k = 0; k < nb; k++) d.push_back({1'b1, 7'($urandom)});
            last = 8'($urandom);
            if (poll && !rs) last[7] = 1'b0;
            d.push_back(last);
            do_read(1'b0, rs, poll, d, $sformatf("rnd%0d", i));
        end

        // Randomized reads on the limited instance (may time out).
        for (int i = 0; i < 4; i++) begin
            rs   = 1'($urandom);
            poll = 1'($urandom);
            nb   = $urandom_range(0, 6);
            d    = {};
            for (int k = 0; k < nb; k++) d.push_back({1'b1, 7'($urandom)});
            d.push_back(8'($urandom));
            do_read(1'b1, rs, poll, d, $sformatf("lim%0d", i));
        end

        // Reset asserted while E is high.
        @(negedge C);
        q0 = {8'h5A}; db0 = 8'h5A;
        t_sel = 1'b0; t_rs = 1'b0; t_poll = 1'b0; t_req = 1'b1;
        @(negedge C);
        t_req = 1'b0;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus0.LCD_E) begin
                found = 1;
                break;
            end
            @(negedge C);
        end
        check("arst.e_seen", found, 1);
        #2 nR = 1'b0;
        #1;
        check("arst.e",    bus0.LCD_E, 1'b0);
        check("arst.rw",   bus0.LCD_RW, 1'b0);
        check("arst.busy", bus0.BUSY, 1'b0);
        check("arst.own",  bus0.BUS_OWN, 1'b0);
        check("arst.dout", bus0.DOUT, 8'h00);
        @(negedge C);
        nR = 1'b1;
        d = {8'h4B};
        do_read(1'b0, 1'b0, 1'b0, d, "after_rst");

        // REQ held high for 200 cycles: back-to-back reads, one IDLE cycle apart.
        @(negedge C);
        q0 = {8'h33}; db0 = 8'h33;
        t_sel = 1'b0; t_rs = 1'b0; t_poll = 1'b0; t_req = 1'b1;
        done_cnt = 0; gaps = 0; bad_gap = 0; low_run = 0; seen_busy = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge C);
            if (bus0.DONE) done_cnt++;
            if (bus0.BUSY) begin
                if (seen_busy && low_run > 0) begin
                    gaps++;
                    if (low_run != 1) bad_gap++;
                end
                seen_busy = 1'b1;
                low_run   = 0;
            end else begin
                low_run++;
            end
        end
        t_req = 1'b0;
        check("cont.done_cnt", done_cnt, (199 - CYC) / (CYC + 2) + 1);
        check("cont.gaps",     gaps, 199 / (CYC + 2));
        check("cont.bad_gap",  bad_gap, 0);
        found = 0;
        for (int k = 0; k < 2 * CYC; k++) begin
            @(negedge C);
            if (!bus0.BUSY) begin
                found = 1;
                break;
            end
        end
        check("cont.drain", found, 1);
        check("cont.dout",  bus0.DOUT, 8'h33);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_rd_ctrl.md
Name: lcd_rd_ctrl

Overview:
Read-side bus controller for the HD44780-compatible LCD1602 panel. It is the counterpart of the existing write-side control unit. On request it drives one LCD read cycle (RW=1) with correct setup, enable-pulse, hold and recovery timing, and samples DB[7:0]. It returns either the busy flag plus address counter (RS=0) or a DDRAM/CGRAM byte (RS=1). An optional poll mode repeats busy-flag reads until BF=0 or a poll limit is reached. While a read is in progress it owns the bus, and the writer must tri-state DB.

Parameters:
T_AS, 3, clock cycles RS/RW set up before E rises (≥60 ns at 50 MHz); legal 1..255
T_PW, 25, clock cycles E held high; DB sampled on the last of these (≥450 ns); legal 1..255
T_H, 2, clock cycles RW held at 1 after E falls; legal 1..255
T_REC, 25, clock cycles E low before the next cycle or completion; legal 1..255
MAX_POLL, 1000, maximum number of BF reads in poll mode; legal 1..65535

Ports:
C  in  1  system clock, rising edge
nR  in  1  asynchronous active-low reset
REQ  in  1  start a read; sampled only in IDLE
RS_SEL  in  1  0 = read BF/AC, 1 = read data byte
POLL  in  1  1 = repeat BF reads until BF=0; ignored when RS_SEL=1
BUSY  out  1  high from REQ acceptance through the DONE cycle
BUS_OWN  out  1  high while LCD_RW=1; the writer must keep DB tri-stated
DONE  out  1  one-cycle completion pulse
DOUT  out  8  last byte sampled from DB
BF  out  1  DOUT[7] when RS_SEL=0 was used; 0 otherwise
AC  out  7  DOUT[6:0] when RS_SEL=0 was used; 0 otherwise
TIMEOUT  out  1  set together with DONE when the poll limit is hit with BF still 1
LCD_RS  out  1  panel RS
LCD_RW  out  1  panel R/W
LCD_E  out  1  panel enable
DB_I  in  8  panel data bus input

Behaviour:
- All outputs are registered.
- Reset value of every output: 0. This includes LCD_E=0 and LCD_RW=0, which are applied immediately on nR low, including mid-cycle.
- Reset also clears the state (to IDLE), the timer, the poll count, and the latched RS_SEL/POLL.

State machine:
- IDLE: LCD_RW=0, LCD_E=0. On REQ=1 at edge k:
  - latch RS_SEL and POLL&~RS_SEL;
  - set LCD_RS=RS_SEL, LCD_RW=1, BUSY=1, BUS_OWN=1;
  - clear poll count to 1 and TIMEOUT to 0;
  - go to SETUP.
- SETUP: lasts T_AS cycles, then go to EHIGH with LCD_E=1.
- EHIGH: lasts T_PW cycles. On the edge that leaves EHIGH:
  - capture DB_I into DOUT;
  - set LCD_E=0;
  - go to HOLD.
- HOLD: lasts T_H cycles, then set LCD_RW=0 and BUS_OWN=0, and go to RECOVER.
- RECOVER: lasts T_REC cycles, then:
  - if latched poll=1, DOUT[7]=1 and poll count<MAX_POLL: increment poll count, set LCD_RW=1 and BUS_OWN=1, go to SETUP;
  - else if latched poll=1 and DOUT[7]=1: set TIMEOUT=1, go to FIN;
  - else: go to FIN.
- FIN: DONE=1 for one cycle. BF/AC are updated from DOUT when the latched RS_SEL=0, else both are cleared. Next state is IDLE, with BUSY=0.

Timing and latency:
- Latency of a single read: DONE is high in the cycle after edge k+T_AS+T_PW+T_H+T_REC (55 at defaults).
- Each additional poll iteration adds T_AS+T_PW+T_H+T_REC cycles.
- LCD_RS is stable from one cycle before SETUP until RECOVER ends. LCD_RS changes only in IDLE.

Boundary conditions:
- REQ while BUSY=1: ignored, with no queuing.
- REQ held high continuously: a new read starts in the IDLE cycle after FIN. That gives at least one IDLE cycle between reads.
- DOUT, BF, AC and TIMEOUT hold their values until the next FIN or reset.
- DB_I is sampled without a synchronizer. Panel data is stable T_PW−T_DDR before sampling, so T_PW ≥ 20 at 50 MHz is required.
- Timer: 8-bit down-counter loaded with (param−1); a state exits when the counter reaches 0.
- Poll counter: 16 bits, saturating; it cannot wrap.

Decomposition:
- Shared package lcd_rd_pkg:
  - state encoding (IDLE, SETUP, EHIGH, HOLD, RECOVER, FIN);
  - default timing constants at 50 MHz;
  - RS encoding constants (RS_INSTR=0, RS_DATA=1).
- One sub-module, lcd_rd_timer:
  - 8-bit loadable down-counter;
  - inputs load, value; output zero;
  - clocked by C, reset by nR.

Test Plan:
- Reset, then REQ=1 for one cycle with RS_SEL=0, POLL=0, DB_I=8'h25:
  - LCD_E is high for exactly 25 cycles, starting 3 cycles after acceptance;
  - LCD_RW drops 2 cycles after E falls;
  - DONE pulses 55 cycles after acceptance with DOUT=8'h25, BF=0, AC=7'h25, TIMEOUT=0.
- RS_SEL=1, DB_I=8'hC1: LCD_RS=1 throughout the cycle; DONE gives DOUT=8'hC1 with BF=0 and AC=0.
- POLL=1, RS_SEL=0, DB_I=8'h80 for the first 3 reads, then 8'h0A: exactly 4 E pulses; DONE with BF=0, AC=7'h0A, TIMEOUT=0.
- POLL=1 with MAX_POLL=4 and DB_I fixed at 8'hFF: exactly 4 E pulses; DONE with TIMEOUT=1 and BF=1.
- Assert nR during EHIGH: LCD_E=0, LCD_RW=0, BUSY=0 and BUS_OWN=0 immediately, without waiting for a clock edge. After release, a new REQ completes normally.
- Hold REQ=1 continuously for 200 cycles: successive reads are separated by exactly one IDLE cycle; DONE count = 3.
